key_load_strobe: RTL
====================

# key_load_strobe

Press-to-load front end for the 8-bit switch register path. Takes a raw, bouncing, active-low pushbutton plus an 8-bit switch word and produces one clean, debounced load event per physical press. Each event carries a snapshot of the switch word, offered to a downstream register through a valid/ready handshake. It is the writer side of the register load interface and replaces direct use of a raw key as a register clock.

## Interface
- `N`, default 8: data width.
- `DEBOUNCE_CYCLES`, default 500000: cycles a level must stay stable to be accepted (10 ms at 50 MHz). Must be at least 2.
- `CNT_W`, default 8: width of the press counter.

- `Clock`, input, 1: single system clock. All state is on its rising edge.
- `Resetn`, input, 1: asynchronous, active-low reset.
- `KEY_n`, input, 1: raw pushbutton, asynchronous to `Clock`. 0 = pressed.
- `SW`, input, `N`: switch word, asynchronous, quasi-static.
- `Ready`, input, 1: consumer can accept data this cycle.
- `Valid`, output, 1: `Data` holds an unconsumed snapshot.
- `Data`, output, `N`: snapshot of `SW` taken at press acceptance.
- `Load`, output, 1: one-cycle pulse on every handshake transfer (`Valid && Ready`).
- `Overrun`, output, 1: sticky. Set when a press is accepted while `Valid` is still high.
- `Presses`, output, `CNT_W`: count of accepted presses, wraps modulo 2^`CNT_W`.

## Operation
- **Synchronizer:** two-flop synchronizer on `KEY_n`, reset value 1 (released). `SW` is registered once, with reset value 0. All logic below uses the synchronized values.
- **Debounce counter:** `DEBOUNCE_CYCLES`-range, cleared whenever the synchronized key equals the current stable state, or when it changes level mid-count.
- **FSM states:**
  - `IDLE`: stable released. Synchronized key = 0 → `PRESS_WAIT`, counter cleared.
  - `PRESS_WAIT`: key returns to 1 before count completes → `IDLE` (bounce rejected). Counter reaches `DEBOUNCE_CYCLES-1` with key still 0 → press accepted, go to `HELD`.
  - `HELD`: stable pressed. Synchronized key = 1 → `RELEASE_WAIT`.
  - `RELEASE_WAIT`: key returns to 0 before count completes → `HELD`. Count completes with key at 1 → `IDLE`.
- **Press acceptance (single cycle):**
  - `Data` ← registered `SW`.
  - `Valid` ← 1.
  - `Presses` increments.
  - If `Valid` was already 1 and no transfer happens in this cycle: `Overrun` ← 1, and the old `Data` is overwritten (newest wins).
  - If a transfer and an acceptance happen in the same cycle: the transfer consumes the old `Data`, the new snapshot loads, `Valid` stays 1, and no overrun is flagged.
- **Handshake:**
  - `Valid` stays high and `Data` stays stable until `Valid && Ready`.
  - `Valid` falls the cycle after the transfer unless a new acceptance coincides with it.
  - `Ready` may be tied high.
- **Hold and release:** holding the key never produces more than one acceptance. Release produces none.
- **Reset values:** FSM = `IDLE`, `Valid` = 0, `Data` = 0, `Load` = 0, `Overrun` = 0, `Presses` = 0, counter = 0. Reset can assert at any point, including mid-debounce or while `Valid` is pending. The pending data is discarded.

## Timing
- **Press latency:** the key falls at cycle t and stays low. After 2 synchronizer cycles, the FSM enters `PRESS_WAIT` at t+2. Acceptance and `Valid` = 1 occur at t+2+`DEBOUNCE_CYCLES`.
- **Handshake:** `Load` is high in the same cycle as `Valid && Ready`. It is combinational from the registered `Valid` and the `Ready` input.
- **Snapshot timing:** `Data` reflects `SW` as registered in the acceptance cycle, which is `SW` sampled one cycle earlier.
- **Minimum spacing:** two accepted presses are at least 2×`DEBOUNCE_CYCLES` cycles apart.

## Structure
- **Shared package:** the FSM state enum (`IDLE`, `PRESS_WAIT`, `HELD`, `RELEASE_WAIT`) and the default `DEBOUNCE_CYCLES` constant.
- **Sub-module `sync2`:** the two-flop synchronizer with a reset-value parameter. It is reusable for the other key inputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- **Clean press:** reset, `SW` = 8'hA5, `Ready` = 1, key low for 20 cycles → `Valid` and `Load` high in the same cycle, 6 cycles after the key falls. `Data` = 8'hA5, `Presses` = 1, `Overrun` = 0.
- **Bounce rejection:** key toggles every 2 cycles for 12 cycles, then returns high → no `Valid`, `Presses` = 0. A following stable press gives exactly one acceptance.
- **Backpressure:** `Ready` = 0, press with `SW` = 8'h3C, then change `SW` to 8'hFF → `Valid` held and `Data` stays 8'h3C. Raising `Ready` for one cycle gives `Load` = 1, and `Valid` falls the next cycle.
- **Overrun:** `Ready` = 0, two separate presses with `SW` = 8'h11 then 8'h22 → `Overrun` = 1 and stays set, `Data` = 8'h22, `Presses` = 2.
- **Counter wrap with long hold:** 256 presses with `Ready` = 1 → `Presses` wraps to 0. One additional press held 100 cycles → exactly one acceptance.
- **Reset mid-operation:** assert `Resetn` low during `PRESS_WAIT`, and separately with `Valid` pending → all outputs return to 0 immediately. After release, the FSM is in `IDLE` and there is no spurious `Valid`.

Source files
------------

// File: rtl/key_load_strobe_pkg.sv
// Shared definitions for the debounced key-load front end.
//   key_state_e             : debounce FSM states
//   DEBOUNCE_CYCLES_DEFAULT : stable-level window (10 ms at 50 MHz)
package key_load_strobe_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/key_load_strobe_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   i_clk   : destination clock
//   i_rst_n : async active-low reset, both flops load RST_VAL
//   i_d     : asynchronous input
//   o_q     : synchronized output (two cycles of latency)
module key_load_strobe_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_load_strobe.sv
// Debounced press-to-load front end: one SW snapshot per physical key press,
// offered downstream over a valid/ready handshake.
//   Clock, Resetn : system clock, async active-low reset
//   KEY_n         : raw bouncing pushbutton, 0 = pressed
//   SW            : quasi-static switch word
//   Ready         : consumer accepts this cycle
//   Valid, Data   : pending snapshot and its flag
//   Load          : combinational transfer strobe (Valid && Ready)
//   Overrun       : sticky, a press landed on an unconsumed snapshot
//   Presses       : accepted press count, wraps
module key_load_strobe
  import key_load_strobe_pkg::*;
#(
  parameter int unsigned N               = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             KEY_n,
  input  logic [N-1:0]     SW,
  input  logic             Ready,
  output logic             Valid,
  output logic [N-1:0]     Data,
  output logic             Load,
  output logic             Overrun,
  output logic [CNT_W-1:0] Presses
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic             w_key;
  logic [N-1:0]     r_sw;
  key_state_e       r_state;
  key_state_e       w_state_nxt;
  logic [DB_W-1:0]  r_cnt;
  logic [DB_W-1:0]  w_cnt_nxt;
  logic             w_accept;
  logic             w_load;
  logic             r_valid;
  logic [N-1:0]     r_data;
  logic             r_overrun;
  logic [CNT_W-1:0] r_presses;

  // Key synchronizer resets to released so reset never looks like a press
  key_load_strobe_sync2 #(.RST_VAL(1'b1)) u_key_sync (
    .i_clk   (Clock),
    .i_rst_n (Resetn),
    .i_d     (KEY_n),
    .o_q     (w_key)
  );

  // Single register stage on the switch word; snapshot source
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) r_sw <= '0;
    else         r_sw <= SW;
  end

  // FSM and debounce counter registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; counter runs only in the wait states and clears on any level flip
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_key) w_state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (w_key) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = HELD;
          w_accept    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (w_key) w_state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!w_key) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + DB_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_load = r_valid & Ready;

  // Snapshot / handshake; an acceptance coinciding with a transfer keeps Valid up
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
      r_presses <= '0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_data    <= r_sw;
      r_presses <= r_presses + CNT_W'(1);
      if (r_valid && !Ready) r_overrun <= 1'b1;
    end else if (w_load) begin
      r_valid <= 1'b0;
    end
  end

  assign Valid   = r_valid;
  assign Data    = r_data;
  assign Load    = w_load;
  assign Overrun = r_overrun;
  assign Presses = r_presses;

endmodule
